// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between the requesters and the weighted round-robin arbiter.
// The master side drives requests and weights; the slave side is the arbiter.
interface wrr_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WEIGHT_WIDTH   = 4
) ();
    logic [NUM_REQUESTERS-1:0]              request;
    logic [NUM_REQUESTERS*WEIGHT_WIDTH-1:0] weight;
    logic                                   update_lru;
    logic                                   hold;
    logic [NUM_REQUESTERS-1:0]              grant_oh;
    logic [$clog2(NUM_REQUESTERS)-1:0]      grant_idx;
    logic                                   grant_valid;
    logic [NUM_REQUESTERS-1:0]              starved_oh;

    modport master (
        output request, weight, update_lru, hold,
        input  grant_oh, grant_idx, grant_valid, starved_oh
    );

    modport slave (
        input  request, weight, update_lru, hold,
        output grant_oh, grant_idx, grant_valid, starved_oh
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with multi-beat grant locking; grant is combinational.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module wrr_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int STARVE_LIMIT   = 64
) (
    input logic          clk,
    input logic          reset,
    wrr_arbiter_if.slave bus
);
    localparam int N  = NUM_REQUESTERS;
    localparam int W  = WEIGHT_WIDTH;
    localparam int IW = $clog2(N);

    logic [N-1:0]  priority_oh;
    logic [N-1:0]  lock_oh;
    logic [W-1:0]  credit;
    logic          locked;

    logic [N-1:0]  grant;
    logic [N-1:0]  starved;
    logic [N-1:0]  scan_vec;
    logic [IW-1:0] prio_idx;
    logic [IW-1:0] grant_idx;
    logic          lock_req;
    logic          starve_pick;
    logic          grant_valid;
    logic [W-1:0]  grant_weight;
    logic [W:0]    eff_weight;
    logic [W:0]    cnt;

    // First set bit of vec at or after start, scanning circularly.
    function automatic logic [N-1:0] scan_from(
        input logic [N-1:0]  vec,
        input logic [IW-1:0] start
    );
        logic [N-1:0] pick;
        logic         found;
        int           j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && vec[j[IW-1:0]]) begin
                pick[j[IW-1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] wait_cnt [N];

    // Saturating per-requester wait counters; cleared on service or idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((grant[i] && bus.update_lru) || !bus.request[i])
                    wait_cnt[i] <= '0;
                else if (!grant[i] && wait_cnt[i] != SW'(STARVE_LIMIT))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    // A requester is starved once its counter has saturated.
    always_comb begin
        starved = '0;
        for (int i = 0; i < N; i++)
            starved[i] = (wait_cnt[i] == SW'(STARVE_LIMIT));
    end
`else
    assign starved = '0;
`endif

    // Grant selection: live lock first, then starved set, then plain scan.
    always_comb begin
        prio_idx = '0;
        for (int i = 0; i < N; i++)
            if (priority_oh[i]) prio_idx = IW'(i);
        lock_req    = locked && |(bus.request & lock_oh);
        starve_pick = !lock_req && |(starved & bus.request);
        scan_vec    = starve_pick ? (starved & bus.request) : bus.request;
        grant       = lock_req ? lock_oh : scan_from(scan_vec, prio_idx);
        grant_valid = |grant;
        grant_idx   = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) grant_idx = IW'(i);
    end

    // Slot count for the granted unit; zero weight behaves as one.
    always_comb begin
        grant_weight = bus.weight[grant_idx*W +: W];
        eff_weight   = (grant_weight == '0) ? (W+1)'(1) : {1'b0, grant_weight};
        cnt          = (W+1)'(1);
        if (grant == priority_oh && !starve_pick)
            cnt = {1'b0, credit} + (W+1)'(1);
    end

    // Burst lock and weighted rotation state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priority_oh <= N'(1);
            credit      <= '0;
            locked      <= 1'b0;
            lock_oh     <= '0;
        end else begin
            if (bus.hold && grant_valid && !(locked && !lock_req)) begin
                locked  <= 1'b1;
                lock_oh <= grant;
            end else begin
                locked  <= 1'b0;
                lock_oh <= '0;
            end
            if (grant_valid && bus.update_lru && !bus.hold) begin
                if (cnt >= eff_weight) begin
                    priority_oh <= {grant[N-2:0], grant[N-1]};
                    credit      <= '0;
                end else begin
                    priority_oh <= grant;
                    credit      <= cnt[W-1:0];
                end
            end
        end
    end

    assign bus.grant_oh    = grant;
    assign bus.grant_idx   = grant_idx;
    assign bus.grant_valid = grant_valid;
    assign bus.starved_oh  = starved;

    a_prio_onehot: assert property (
        @(posedge clk) disable iff (reset) $onehot(priority_oh));
    a_grant_onehot0: assert property (
        @(posedge clk) disable iff (reset) $onehot0(grant));
endmodule
